// File: rtl/sonar_cap_pkg.sv
// Shared types and defaults for the sonar ping-pong capture buffer.
// No logic of its own: no latency, no backpressure.
// Holds the capture FSM encoding and the address-width helper.
package sonar_cap_pkg;

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } cap_state_t;

    localparam int CHANNELS_DEF = 8;
    localparam int SAMPLE_W_DEF = 8;
    localparam int DEPTH_DEF    = 2048;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sonar_dpram.sv
// One channel's sample store: simple dual-port RAM holding both banks.
// Read data is registered (1 cycle), reset to 0 and held while re is low.
// No backpressure: one write and one read may happen every cycle.
module sonar_dpram #(
    parameter int SAMPLE_W = 8,
    parameter int AW       = 12
) (
    input  logic                clk,
    input  logic                nRST,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [0:(1<<AW)-1];

    // Array has no reset so it maps onto block RAM; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sonar_capture_buffer.sv
// Multi-channel ping-pong capture buffer; SONAR_CAP_DECIM_EN enables mean-decimation.
// Read latency 1 cycle; writes land in the back bank the cycle they are accepted.
// No backpressure: samples in ARM are dropped, samples in FULL are dropped and flag overrun.
module sonar_capture_buffer
    import sonar_cap_pkg::*;
#(
    parameter int CHANNELS   = CHANNELS_DEF,
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DECIM_LOG2 = 2,
    parameter int ADDR_W     = addr_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         nRST,
    input  logic                         mode_trig,
    input  logic                         trigger,
    input  logic                         sample_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
    input  logic                         frame_sync,
    input  logic                         rd_en,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [CHANNELS*SAMPLE_W-1:0] rd_data,
    output logic                         front_bank,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         swap_pulse,
    output logic                         overrun,
    input  logic                         overrun_clr
);

`ifdef SONAR_CAP_DECIM_EN
    localparam int DLOG = DECIM_LOG2;
`else
    // Factor-1 decimation: every accepted sample completes a group and is stored as-is.
    localparam int DLOG = DECIM_LOG2 - DECIM_LOG2;
`endif
    localparam int SUM_W = SAMPLE_W + DLOG;
    localparam int PH_W  = (DLOG > 0) ? DLOG : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DLOG) - 1);

    cap_state_t state, state_nx;
    logic [PH_W-1:0] phase;
    logic accept, group_done, last_wr;

    assign accept     = (state == FILL) && sample_valid;
    assign group_done = accept && (phase == PH_LAST);
    assign last_wr    = group_done && (wr_addr == ADDR_W'(DEPTH - 1));
    assign swap_pulse = (state == FULL) && frame_sync;

    always_comb begin
        state_nx = state;
        case (state)
            ARM:     if (!mode_trig || trigger) state_nx = FILL;
            FILL:    if (last_wr)               state_nx = FULL;
            FULL:    if (frame_sync)            state_nx = ARM;
            default:                            state_nx = ARM;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state      <= ARM;
            wr_addr    <= '0;
            front_bank <= 1'b0;
            overrun    <= 1'b0;
            phase      <= '0;
        end else begin
            state <= state_nx;
            // DEPTH is a power of two, so the last write wraps wr_addr back to 0.
            if (group_done) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
            if (swap_pulse) begin
                front_bank <= ~front_bank;
            end
            // A new drop outranks a simultaneous clear.
            overrun <= (state == FULL && sample_valid) || (overrun && !overrun_clr);
            if (state != FILL || group_done) begin
                phase <= '0;
            end else if (accept) begin
                phase <= phase + PH_W'(1);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SAMPLE_W-1:0] smp;
        logic [SUM_W-1:0]    acc;
        logic [SUM_W-1:0]    sum;
        logic [SAMPLE_W-1:0] mean;

        assign smp  = sample_data[c*SAMPLE_W +: SAMPLE_W];
        assign sum  = acc + SUM_W'(smp);
        assign mean = SAMPLE_W'(sum >> DLOG);

        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                acc <= '0;
            end else if (state != FILL || group_done) begin
                acc <= '0;
            end else if (accept) begin
                acc <= sum;
            end
        end

        sonar_dpram #(
            .SAMPLE_W (SAMPLE_W),
            .AW       (ADDR_W + 1)
        ) u_ram (
            .clk   (clk),
            .nRST  (nRST),
            .we    (group_done),
            .waddr ({~front_bank, wr_addr}),
            .wdata (mean),
            .re    (rd_en),
            .raddr ({front_bank, rd_addr}),
            .rdata (rd_data[c*SAMPLE_W +: SAMPLE_W])
        );
    end

endmodule

// File: tb/tb_sonar_capture_buffer.sv
// Directed bench for sonar_capture_buffer with a sample-count reference model.
module tb_sonar_capture_buffer;

    localparam int CH = 4;
    localparam int SW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 4;
`ifdef SONAR_CAP_DECIM_EN
    localparam int F = 4;
`else
    localparam int F = 1;
`endif

    logic clk = 1'b0;
    logic nRST = 1'b1;
    logic mode_trig = 1'b0;
    logic trigger = 1'b0;
    logic sample_valid = 1'b0;
    logic [CH*SW-1:0] sample_data = '0;
    logic frame_sync = 1'b0;
    logic rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic overrun_clr = 1'b0;
    logic [CH*SW-1:0] rd_data;
    logic front_bank;
    logic [AW-1:0] wr_addr;
    logic swap_pulse;
    logic overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int n_swaps = 0;

    sonar_capture_buffer #(
        .CHANNELS(CH), .SAMPLE_W(SW), .DEPTH(DEPTH), .DECIM_LOG2(2)
    ) dut (
        .clk(clk), .nRST(nRST), .mode_trig(mode_trig), .trigger(trigger),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .frame_sync(frame_sync), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .front_bank(front_bank), .wr_addr(wr_addr),
        .swap_pulse(swap_pulse), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: a fill is a count of stored groups; the bank is full when the count reaches DEPTH.
    bit m_front = 0;
    bit m_active = 0;
    int m_stored = 0;
    int m_raw = 0;
    bit m_ovr = 0;
    bit m_rd_known = 1;
    int m_rd [CH];
    int sums [CH];
    int mem [2][DEPTH][CH];
    bit memv [2][DEPTH];

    always @(posedge clk or negedge nRST) begin
        bit full;
        bit old_front;
        if (!nRST) begin
            m_front = 0; m_active = 0; m_stored = 0; m_raw = 0; m_ovr = 0;
            m_rd_known = 1;
            for (int c = 0; c < CH; c++) begin m_rd[c] = 0; sums[c] = 0; end
        end else begin
            full = m_active && (m_stored == DEPTH);
            old_front = m_front;
            if (rd_en) begin
                m_rd_known = memv[old_front][int'(rd_addr)];
                for (int c = 0; c < CH; c++) m_rd[c] = mem[old_front][int'(rd_addr)][c];
            end
            if (!m_active) begin
                if (!mode_trig || trigger) begin
                    m_active = 1; m_stored = 0; m_raw = 0;
                    for (int c = 0; c < CH; c++) sums[c] = 0;
                end
            end else if (!full) begin
                if (sample_valid) begin
                    m_raw++;
                    for (int c = 0; c < CH; c++) sums[c] += int'(sample_data[c*SW +: SW]);
                    if (m_raw % F == 0) begin
                        for (int c = 0; c < CH; c++) begin
                            mem[!m_front][m_stored][c] = sums[c] / F;
                            sums[c] = 0;
                        end
                        memv[!m_front][m_stored] = 1;
                        m_stored++;
                    end
                end
            end else if (frame_sync) begin
                m_front = !m_front; m_active = 0; m_stored = 0;
            end
            if (full && sample_valid) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
        end
    end

    always @(negedge clk) begin
        check("wr_addr", 64'(wr_addr), 64'(m_stored % DEPTH));
        check("front_bank", 64'(front_bank), 64'(m_front));
        check("swap_pulse", 64'(swap_pulse),
              64'(m_active && m_stored == DEPTH && frame_sync && nRST));
        check("overrun", 64'(overrun), 64'(m_ovr));
        if (m_rd_known)
            for (int c = 0; c < CH; c++)
                check("rd_data", 64'(rd_data[c*SW +: SW]), 64'(m_rd[c] & 255));
        if (swap_pulse === 1'b1) n_swaps++;
    end

    function automatic logic [CH*SW-1:0] pat(input int v);
        logic [CH*SW-1:0] r;
        for (int c = 0; c < CH; c++) r[c*SW +: SW] = SW'(v + c * 32);
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        sample_valid = 1'b1;
        sample_data = pat(v);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic send_rep(input int v);
        repeat (F) send(v);
    endtask

    task automatic fill(input int base, input int n);
        for (int i = 0; i < n; i++) send_rep(base + i);
    endtask

    task automatic do_reset(input logic trig_mode);
        nRST = 1'b0;
        mode_trig = trig_mode;
        tick(); tick();
        nRST = 1'b1;
    endtask

    task automatic swap_now;
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
    endtask

    task automatic read_chk(input int a, input int exp0);
        rd_en = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en = 1'b0;
        check("read_lit", 64'(rd_data[SW-1:0]), 64'(exp0));
    endtask

    task automatic arm_trigger;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    initial begin
        #1;
        // 1: free-run fill of 0..15 then swap
        do_reset(1'b0);
        check("reset_wr_addr", 64'(wr_addr), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        tick();
        n_swaps = 0;
        fill(0, DEPTH);
        swap_now();
        check("t1_front", 64'(front_bank), 64'd1);
        for (int a = 0; a < DEPTH; a++) read_chk(a, a);
        check("t1_ch3_addr15", 64'(rd_data[3*SW +: SW]), 64'd111);
        check("t1_swaps", 64'(n_swaps), 64'd1);

        // 2: triggered, pre-trigger samples are dropped
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) send(100 + i);
        arm_trigger();
        fill(50, DEPTH);
        check("t2_overrun", 64'(overrun), 64'd0);
        swap_now();
        for (int a = 0; a < DEPTH; a++) read_chk(a, 50 + a);

        // 3: overrun set, clear, and set-wins
        arm_trigger();
        fill(20, DEPTH);
        repeat (3) send(200);
        check("t3_ovr_set", 64'(overrun), 64'd1);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
        check("t3_ovr_clr", 64'(overrun), 64'd0);
        overrun_clr = 1'b1; sample_valid = 1'b1; tick();
        overrun_clr = 1'b0; sample_valid = 1'b0;
        check("t3_set_wins", 64'(overrun), 64'd1);
        overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;

        // 4: last write coincides with frame_sync; read in swap cycle sees old bank
        swap_now();
        check("t4_front0", 64'(front_bank), 64'd0);
        arm_trigger();
        fill(70, DEPTH - 1);
        repeat (F - 1) send(85);
        sample_valid = 1'b1; sample_data = pat(85); frame_sync = 1'b1;
        #1 check("t4_no_swap_on_last", 64'(swap_pulse), 64'd0);
        tick();
        sample_valid = 1'b0; rd_en = 1'b1; rd_addr = AW'(3);
        #1 check("t4_swap_next", 64'(swap_pulse), 64'd1);
        tick();
        frame_sync = 1'b0; rd_en = 1'b0;
        check("t4_old_bank_read", 64'(rd_data[SW-1:0]), 64'd23);
        check("t4_front1", 64'(front_bank), 64'd1);

        // 5: asynchronous reset mid-fill
        arm_trigger();
        fill(0, 7);
        check("t5_wr7", 64'(wr_addr), 64'd7);
        nRST = 1'b0;
        #1;
        check("t5_wr_addr", 64'(wr_addr), 64'd0);
        check("t5_front", 64'(front_bank), 64'd0);
        check("t5_rd_data", 64'(rd_data), 64'd0);
        check("t5_swap", 64'(swap_pulse), 64'd0);
        tick();
        nRST = 1'b1;
        send(1);
        check("t5_arm_drops", 64'(wr_addr), 64'd0);

`ifdef SONAR_CAP_DECIM_EN
        // 6: decimation by 4: 4,8,12,16 -> 10
        mode_trig = 1'b0;
        tick();
        send(4); send(8); send(12);
        check("t6_wr_hold", 64'(wr_addr), 64'd0);
        send(16);
        check("t6_wr_step", 64'(wr_addr), 64'd1);
        fill(1, DEPTH - 1);
        swap_now();
        read_chk(0, 10);
        check("t6_ch1_mean", 64'(rd_data[SW +: SW]), 64'd42);
`endif

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
